rpn_sequenciador: RTL and testbench

- Control and stack block for the 8-bit RPN ALU.
- Holds an operand stack and accepts PUSH and operation commands.
- For each operation, pops operands onto the ALU inputs, waits one cycle for the combinational ALU, writes the result back, and pulses the carry register's load enable.
- Sits between the keypad/switch input logic and the ALU plus its 1-bit carry register.

---
 rtl/rpn_pkg.sv | 28 ++
 rtl/rpn_sequenciador_if.sv | 36 +++
 rtl/rpn_pilha.sv | 62 ++++++
 rtl/rpn_sequenciador.sv | 140 ++++++++++++++
 tb/tb_rpn_sequenciador.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// Shared opcodes, FSM states, error codes and opcode helpers for the RPN sequencer.
package rpn_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_INV = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_INV  = 2'b11;

    function automatic logic IS_UNARY(input logic [2:0] op);
        return (op == OP_NOT) || (op == OP_SHL);
    endfunction

    function automatic logic IS_VALID(input logic [2:0] op);
        return op != OP_INV;
    endfunction

endpackage

// File: rtl/rpn_sequenciador_if.sv
// Command, ALU and status bundle between input logic, sequencer and ALU.
interface rpn_sequenciador_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    logic             PUSH;
    logic             OP_GO;
    logic             CLEAR;
    logic [2:0]       OPCODE;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [2:0]       ALU_OP;
    logic [WIDTH-1:0] ALU_RESULT;
    logic             CARRY_ENABLE;
    logic [WIDTH-1:0] TOP;
    logic [DW-1:0]    DEPTH;
    logic             BUSY;
    logic             ERROR;
    logic [1:0]       ERR_CODE;

    modport master (
        output PUSH, OP_GO, CLEAR, OPCODE, DATA_IN, ALU_RESULT,
        input  ALU_A, ALU_B, ALU_OP, CARRY_ENABLE,
        input  TOP, DEPTH, BUSY, ERROR, ERR_CODE
    );

    modport slave (
        input  PUSH, OP_GO, CLEAR, OPCODE, DATA_IN, ALU_RESULT,
        output ALU_A, ALU_B, ALU_OP, CARRY_ENABLE,
        output TOP, DEPTH, BUSY, ERROR, ERR_CODE
    );

endinterface

// File: rtl/rpn_pilha.sv
// Operand stack: storage, depth counter, push / pop2_push / replace_top strobes.
module rpn_pilha #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4,
    localparam int AW         = $clog2(STACK_DEPTH),
    localparam int DW         = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop2_push_i,
    input  logic             replace_top_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] result_i,
    output logic [WIDTH-1:0] top_o,
    output logic [WIDTH-1:0] second_o,
    output logic [DW-1:0]    depth_o
);

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [WIDTH-1:0] mem_d [STACK_DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [AW-1:0]    top_idx, sec_idx, push_idx;

    // Low index bits wrap correctly, including when the stack is full.
    assign push_idx = depth_q[AW-1:0];
    assign top_idx  = depth_q[AW-1:0] - 1'b1;
    assign sec_idx  = depth_q[AW-1:0] - AW'(2);

    assign top_o    = (depth_q == '0) ? '0 : mem_q[top_idx];
    assign second_o = (depth_q < DW'(2)) ? '0 : mem_q[sec_idx];
    assign depth_o  = depth_q;

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (clear_i) begin
            for (int i = 0; i < STACK_DEPTH; i++) mem_d[i] = '0;
            depth_d = '0;
        end else if (push_i) begin
            mem_d[push_idx] = data_i;
            depth_d         = depth_q + 1'b1;
        end else if (pop2_push_i) begin
            mem_d[sec_idx] = result_i;
            depth_d        = depth_q - 1'b1;
        end else if (replace_top_i) begin
            mem_d[top_idx] = result_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
            depth_q <= '0;
        end else begin
            mem_q   <= mem_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/rpn_sequenciador.sv
// RPN ALU sequencer: IDLE->LOAD->EXEC->WB around a combinational ALU.
// RPN_CARRY_CHAIN_EN: carry load enable only for ADD/SUB/SHL.
module rpn_sequenciador
    import rpn_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input logic         CLOCK,
    input logic         RESET,
    rpn_sequenciador_if.slave bus
);

    localparam int DW = $clog2(STACK_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d, fault;
    logic             push, pop2, repl, stk_clr;
    logic [WIDTH-1:0] top, second;
    logic [DW-1:0]    depth;

    rpn_pilha #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_pilha (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .clear_i      (stk_clr),
        .push_i       (push),
        .pop2_push_i  (pop2),
        .replace_top_i(repl),
        .data_i       (bus.DATA_IN),
        .result_i     (res_q),
        .top_o        (top),
        .second_o     (second),
        .depth_o      (depth)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        code_d  = code_q;
        fault   = ERR_NONE;
        push    = 1'b0;
        pop2    = 1'b0;
        repl    = 1'b0;
        stk_clr = 1'b0;
        if (bus.CLEAR) begin
            state_d = IDLE;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            stk_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.OP_GO) begin
                        if (!IS_VALID(bus.OPCODE)) begin
                            fault = ERR_INV;
                        end else if (IS_UNARY(bus.OPCODE)) begin
                            if (depth != '0) begin
                                a_d     = top;
                                b_d     = '0;
                                op_d    = bus.OPCODE;
                                state_d = LOAD;
                            end else begin
                                fault = ERR_UNF;
                            end
                        end else if (depth >= DW'(2)) begin
                            a_d     = second;
                            b_d     = top;
                            op_d    = bus.OPCODE;
                            state_d = LOAD;
                        end else begin
                            fault = ERR_UNF;
                        end
                    end else if (bus.PUSH) begin
                        if (depth == DW'(STACK_DEPTH)) fault = ERR_OVF;
                        else push = 1'b1;
                    end
                end
                LOAD: state_d = EXEC;
                EXEC: begin
                    res_d   = bus.ALU_RESULT;
                    state_d = WB;
                end
                WB: begin
                    state_d = IDLE;
                    if (IS_UNARY(op_q)) repl = 1'b1;
                    else pop2 = 1'b1;
                end
            endcase
            // Only the first error since CLEAR/RESET is reported.
            if (fault != ERR_NONE) begin
                err_d = 1'b1;
                if (!err_q) code_d = fault;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

`ifdef RPN_CARRY_CHAIN_EN
    assign bus.CARRY_ENABLE = (state_q == WB) &&
        ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SHL));
`else
    assign bus.CARRY_ENABLE = (state_q == WB);
`endif

    assign bus.ALU_A    = a_q;
    assign bus.ALU_B    = b_q;
    assign bus.ALU_OP   = op_q;
    assign bus.TOP      = top;
    assign bus.DEPTH    = depth;
    assign bus.BUSY     = (state_q != IDLE);
    assign bus.ERROR    = err_q;
    assign bus.ERR_CODE = code_q;

endmodule

// File: tb/tb_rpn_sequenciador.sv
// Directed bench for rpn_sequenciador with a behavioural ALU model.
module tb_rpn_sequenciador;

    logic CLOCK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   passed = 0;
    int   ce;

    always #5 CLOCK = ~CLOCK;

    rpn_sequenciador_if #(.WIDTH(8), .STACK_DEPTH(4)) bus ();

    rpn_sequenciador #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always_comb begin
        case (bus.ALU_OP)
            3'd0:    bus.ALU_RESULT = bus.ALU_A + bus.ALU_B;
            3'd1:    bus.ALU_RESULT = bus.ALU_A - bus.ALU_B;
            3'd2:    bus.ALU_RESULT = bus.ALU_A & bus.ALU_B;
            3'd3:    bus.ALU_RESULT = bus.ALU_A | bus.ALU_B;
            3'd4:    bus.ALU_RESULT = bus.ALU_A ^ bus.ALU_B;
            3'd5:    bus.ALU_RESULT = ~bus.ALU_A;
            3'd6:    bus.ALU_RESULT = bus.ALU_A << 1;
            default: bus.ALU_RESULT = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.PUSH    = 1'b1;
        bus.DATA_IN = v;
        tick();
        bus.PUSH    = 1'b0;
    endtask

    // Issues an op and counts CARRY_ENABLE over the three busy cycles.
    task automatic run_op(input logic [2:0] op, output int pulses);
        bus.OP_GO  = 1'b1;
        bus.OPCODE = op;
        tick();
        bus.OP_GO  = 1'b0;
        pulses     = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.CARRY_ENABLE === 1'b1) pulses++;
            tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},    32'(bus.ALU_A), 0);
        chk({tag, "_b"},    32'(bus.ALU_B), 0);
        chk({tag, "_op"},   32'(bus.ALU_OP), 0);
        chk({tag, "_top"},  32'(bus.TOP), 0);
        chk({tag, "_dep"},  32'(bus.DEPTH), 0);
        chk({tag, "_ce"},   32'(bus.CARRY_ENABLE), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
        chk({tag, "_err"},  32'(bus.ERROR), 0);
        chk({tag, "_code"}, 32'(bus.ERR_CODE), 0);
    endtask

    initial begin
        RESET       = 1'b1;
        bus.PUSH    = 1'b0;
        bus.OP_GO   = 1'b0;
        bus.CLEAR   = 1'b0;
        bus.OPCODE  = 3'd0;
        bus.DATA_IN = 8'h00;
        #3;
        chk_zero("rst");
        tick();
        RESET = 1'b0;
        tick();

        push(8'h05);
        push(8'h03);
        chk("t1_dep2", 32'(bus.DEPTH), 2);
        chk("t1_top3", 32'(bus.TOP), 32'h03);
        bus.OP_GO  = 1'b1;
        bus.OPCODE = 3'd0;
        tick();
        bus.OP_GO  = 1'b0;
        chk("t1_busy0", 32'(bus.BUSY), 1);
        chk("t1_a", 32'(bus.ALU_A), 32'h05);
        chk("t1_b", 32'(bus.ALU_B), 32'h03);
        chk("t1_ce_load", 32'(bus.CARRY_ENABLE), 0);
        tick();
        chk("t1_busy1", 32'(bus.BUSY), 1);
        chk("t1_ce_exec", 32'(bus.CARRY_ENABLE), 0);
        tick();
        chk("t1_busy2", 32'(bus.BUSY), 1);
        chk("t1_ce_wb", 32'(bus.CARRY_ENABLE), 1);
        tick();
        chk("t1_idle", 32'(bus.BUSY), 0);
        chk("t1_ce_off", 32'(bus.CARRY_ENABLE), 0);
        chk("t1_top", 32'(bus.TOP), 32'h08);
        chk("t1_dep", 32'(bus.DEPTH), 1);

        push(8'h0F);
        bus.OP_GO  = 1'b1;
        bus.OPCODE = 3'd5;
        tick();
        bus.OP_GO  = 1'b0;
        chk("t2_not_a", 32'(bus.ALU_A), 32'h0F);
        chk("t2_not_b", 32'(bus.ALU_B), 0);
        repeat (3) tick();
        chk("t2_not_top", 32'(bus.TOP), 32'hF0);
        chk("t2_not_dep", 32'(bus.DEPTH), 2);
        run_op(3'd0, ce);
        chk("t2_add_top", 32'(bus.TOP), 32'hF8);
        chk("t2_add_dep", 32'(bus.DEPTH), 1);
        run_op(3'd2, ce);
        chk("t2_unf_err", 32'(bus.ERROR), 1);
        chk("t2_unf_code", 32'(bus.ERR_CODE), 2);
        chk("t2_unf_dep", 32'(bus.DEPTH), 1);
        chk("t2_unf_top", 32'(bus.TOP), 32'hF8);

        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        chk("t3_clr_err", 32'(bus.ERROR), 0);
        chk("t3_clr_dep", 32'(bus.DEPTH), 0);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'hAA);
        chk("t3_ovf_err", 32'(bus.ERROR), 1);
        chk("t3_ovf_code", 32'(bus.ERR_CODE), 1);
        chk("t3_ovf_dep", 32'(bus.DEPTH), 4);
        chk("t3_ovf_top", 32'(bus.TOP), 32'h44);
        run_op(3'd7, ce);
        chk("t3_inv_code", 32'(bus.ERR_CODE), 1);
        chk("t3_inv_err", 32'(bus.ERROR), 1);
        chk("t3_inv_dep", 32'(bus.DEPTH), 4);
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        chk("t3_clr2_err", 32'(bus.ERROR), 0);
        chk("t3_clr2_code", 32'(bus.ERR_CODE), 0);
        chk("t3_clr2_dep", 32'(bus.DEPTH), 0);
        chk("t3_clr2_top", 32'(bus.TOP), 0);

        push(8'h10);
        push(8'h01);
        bus.PUSH    = 1'b1;
        bus.DATA_IN = 8'h77;
        bus.OP_GO   = 1'b1;
        bus.OPCODE  = 3'd1;
        tick();
        bus.OP_GO   = 1'b0;
        bus.DATA_IN = 8'h55;
        chk("t4_busy", 32'(bus.BUSY), 1);
        chk("t4_a", 32'(bus.ALU_A), 32'h10);
        chk("t4_b", 32'(bus.ALU_B), 32'h01);
        tick();
        bus.PUSH = 1'b0;
        repeat (2) tick();
        chk("t4_top", 32'(bus.TOP), 32'h0F);
        chk("t4_dep", 32'(bus.DEPTH), 1);
        chk("t4_err", 32'(bus.ERROR), 0);

        push(8'h02);
        bus.OP_GO  = 1'b1;
        bus.OPCODE = 3'd0;
        tick();
        bus.OP_GO  = 1'b0;
        tick();
        #2;
        RESET = 1'b1;
        #1;
        chk_zero("t5");
        tick();
        RESET = 1'b0;
        ce = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.CARRY_ENABLE === 1'b1) ce++;
            tick();
        end
        chk("t5_ce_never", 32'(ce), 0);
        chk("t5_dep", 32'(bus.DEPTH), 0);
        chk("t5_top", 32'(bus.TOP), 0);

        push(8'h0F);
        push(8'h3C);
        run_op(3'd4, ce);
`ifdef RPN_CARRY_CHAIN_EN
        chk("t6_xor_ce", 32'(ce), 0);
`else
        chk("t6_xor_ce", 32'(ce), 1);
`endif
        chk("t6_xor_top", 32'(bus.TOP), 32'h33);
        chk("t6_xor_dep", 32'(bus.DEPTH), 1);
        run_op(3'd6, ce);
        chk("t6_shl_ce", 32'(ce), 1);
        chk("t6_shl_top", 32'(bus.TOP), 32'h66);
        chk("t6_shl_dep", 32'(bus.DEPTH), 1);
        chk("t6_hold_op", 32'(bus.ALU_OP), 6);
        chk("t6_hold_a", 32'(bus.ALU_A), 32'h33);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
